pulse_param_loader: RTL
=======================

// Module: pulse_param_loader
// PURPOSE
//  Upstream stage of the pulse sequencer. Parses framed parameter writes from the host byte stream
//  (UART receiver output) into a shadow set, checks the frame, then commits the whole set atomically
//  to the per/p1wid/del/p2wid/nut_w/nut_d/nut/cp/p_bl/p_bl_off/bl/pu inputs of the pulse sequencer.
//  Emits a one-cycle rx_done strobe on each commit. Never produces a partially updated set.
// PARAMETERS
//  TIMEOUT_CYC  200000  max clk_pll cycles between bytes inside a frame (~1 ms) before abort
//  SYNC_BYTE    8'hA5   frame start marker
// PORTS
//  clk_pll     in   1   200 MHz PLL clock; only clock
//  reset       in   1   asynchronous, active-high reset
//  rx_data     in   8   received byte
//  rx_valid    in   1   one-cycle strobe: rx_data valid
//  per         out  8   period, units of 2^16 cycles
//  p1wid       out  16  first pulse width, cycles
//  del         out  16  inter-pulse delay, cycles
//  p2wid       out  16  pi pulse width, cycles
//  nut_w       out  32  nutation pulse width, cycles
//  nut_d       out  32  nutation pulse delay from period end, cycles
//  cp          out  8   mode: 0 CW, 1 Hahn, >1 CPMG pulse count
//  p_bl        out  8   block lead before echo, cycles
//  p_bl_off    out  16  block-open window, cycles
//  pu, nut, bl out  1   pump enable, nutation enable, blocking enable
//  rx_done     out  1   one-cycle strobe, new set committed
//  frame_err   out  1   one-cycle strobe, frame discarded
//  err_cnt     out  8   discarded-frame count, saturates at 255
// BEHAVIOUR
//  Reset values: per=1 p1wid=30 del=200 p2wid=30 nut_w=50 nut_d=300 cp=3 p_bl=50 p_bl_off=100
//   pu=1 nut=1 bl=1. rx_done=0, frame_err=0, err_cnt=0. Shadow set, byte index and timer cleared.
//  Frame: SYNC_BYTE, 20 payload bytes, [checksum]. Multi-byte fields big-endian.
//   Payload order: per, p1wid[2], del[2], p2wid[2], nut_w[4], nut_d[4], cp, p_bl, p_bl_off[2],
//   flags (bit0 pu, bit1 nut, bit2 bl, bits7:3 ignored).
//  FSM: IDLE -> (rx_valid & rx_data==SYNC_BYTE) -> PAYLOAD. Non-sync bytes in IDLE: dropped, no error.
//   PAYLOAD: each byte goes to shadow[idx], idx++. After byte 19: CKSUM (or commit, see CONFIGURATION).
//   CKSUM: byte == XOR of the 20 payload bytes -> commit, else frame_err. Then IDLE either way.
//  Commit: outputs load from shadow on the clock edge after the last byte is accepted.
//   rx_done is high for exactly that one cycle. Latency from last rx_valid to new outputs: 1 cycle.
//  SYNC_BYTE inside PAYLOAD/CKSUM is treated as data. No resync mid-frame.
//  Timeout: timer clears on every accepted byte and counts in PAYLOAD/CKSUM.
//   At TIMEOUT_CYC: abort to IDLE, frame_err pulse, err_cnt++. Timer is held at 0 in IDLE.
//   If rx_valid coincides with expiry, the byte wins: it is accepted and the timer clears.
//  err_cnt saturates at 255. Outputs hold their last committed values when a frame is discarded.
//  Reset mid-frame: shadow discarded, outputs return to reset defaults immediately (async).
//  rx_valid is sampled every cycle. Back-to-back strobes are legal.
// CONFIGURATION
//  PARAM_CKSUM_EN defined: 22-byte frame with trailing XOR checksum, checked as above.
//  PARAM_CKSUM_EN undefined: 21-byte frame, no CKSUM state. Commit fires on payload byte 19.
//   frame_err is raised only by timeout.
// STRUCTURE
//  Shared package pulses_pkg holds: SYNC_BYTE, PAYLOAD_LEN=20, field byte offsets,
//   reset-default constants (shared with the sequencer's defaults), FSM state typedef.
//  No sub-module: parser, shadow registers and timer live in this module.
// TESTING
//  1. Reset only -> all outputs at defaults; rx_done=0; err_cnt=0.
//  2. Valid frame (per=4, p1wid=40, del=300, p2wid=80, cp=1, flags=3'b101), good checksum
//     -> outputs update 1 cycle after the last byte; rx_done high exactly 1 cycle; nut=0.
//  3. Same frame with checksum^8'h01 -> frame_err pulse, err_cnt=1, outputs unchanged.
//  4. Garbage bytes 8'h00, 8'hFF, then a valid frame containing 8'hA5 in p1wid -> garbage ignored,
//     p1wid=16'hA5xx committed.
//  5. Stall TIMEOUT_CYC cycles after byte 10 -> frame_err, IDLE; a following valid frame commits.
//     Also: a byte on the expiry cycle is accepted.
//  6. Assert reset mid-payload -> defaults restored; 300 bad frames -> err_cnt holds at 255.
//     Repeat 2 and 3 with PARAM_CKSUM_EN undefined (21-byte frame).

Source files
------------

// File: rtl/pulse_param_loader_pkg.sv
// Frame layout, reset defaults and parser state type for the pulse parameter loader.
// The ST_CKSUM state exists only when PARAM_CKSUM_EN is defined.
package pulse_param_loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'hA5;
   localparam int         TIMEOUT_CYC_DEFAULT = 200000;
   localparam int         PAYLOAD_LEN         = 20;

   // Byte offsets of each field inside the payload; multi-byte fields are big-endian
   localparam int OFS_PER      = 0;
   localparam int OFS_P1WID    = 1;
   localparam int OFS_DEL      = 3;
   localparam int OFS_P2WID    = 5;
   localparam int OFS_NUT_W    = 7;
   localparam int OFS_NUT_D    = 11;
   localparam int OFS_CP       = 15;
   localparam int OFS_P_BL     = 16;
   localparam int OFS_P_BL_OFF = 17;
   localparam int OFS_FLAGS    = 19;

   typedef logic [7:0] payload_t [PAYLOAD_LEN];

   typedef struct packed {
      logic [7:0]  per;
      logic [15:0] p1wid;
      logic [15:0] del;
      logic [15:0] p2wid;
      logic [31:0] nut_w;
      logic [31:0] nut_d;
      logic [7:0]  cp;
      logic [7:0]  p_bl;
      logic [15:0] p_bl_off;
      logic        bl;
      logic        nut;
      logic        pu;
   } param_set_t;

   // Same power-up set the sequencer assumes before any host write
   localparam param_set_t PARAM_DEFAULTS = '{
      per:      8'd1,
      p1wid:    16'd30,
      del:      16'd200,
      p2wid:    16'd30,
      nut_w:    32'd50,
      nut_d:    32'd300,
      cp:       8'd3,
      p_bl:     8'd50,
      p_bl_off: 16'd100,
      bl:       1'b1,
      nut:      1'b1,
      pu:       1'b1
   };

   typedef enum logic [1:0] {
      ST_IDLE,
`ifdef PARAM_CKSUM_EN
      ST_PAYLOAD,
      ST_CKSUM
`else
      ST_PAYLOAD
`endif
   } state_t;

   function automatic param_set_t unpack_payload(input payload_t b);
      param_set_t s;
      s.per      = b[OFS_PER];
      s.p1wid    = {b[OFS_P1WID], b[OFS_P1WID + 1]};
      s.del      = {b[OFS_DEL], b[OFS_DEL + 1]};
      s.p2wid    = {b[OFS_P2WID], b[OFS_P2WID + 1]};
      s.nut_w    = {b[OFS_NUT_W], b[OFS_NUT_W + 1], b[OFS_NUT_W + 2], b[OFS_NUT_W + 3]};
      s.nut_d    = {b[OFS_NUT_D], b[OFS_NUT_D + 1], b[OFS_NUT_D + 2], b[OFS_NUT_D + 3]};
      s.cp       = b[OFS_CP];
      s.p_bl     = b[OFS_P_BL];
      s.p_bl_off = {b[OFS_P_BL_OFF], b[OFS_P_BL_OFF + 1]};
      s.bl       = b[OFS_FLAGS][2];
      s.nut      = b[OFS_FLAGS][1];
      s.pu       = b[OFS_FLAGS][0];
      return s;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pulse_param_loader_if.sv
// Host byte stream into the loader and the committed pulse parameter set out of it.
// master = byte source / parameter consumer side, slave = the loader.
interface pulse_param_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  per;
   logic [15:0] p1wid;
   logic [15:0] del;
   logic [15:0] p2wid;
   logic [31:0] nut_w;
   logic [31:0] nut_d;
   logic [7:0]  cp;
   logic [7:0]  p_bl;
   logic [15:0] p_bl_off;
   logic        pu;
   logic        nut;
   logic        bl;
   logic        rx_done;
   logic        frame_err;
   logic [7:0]  err_cnt;

   modport master (
      output rx_data, rx_valid,
      input  per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off,
             pu, nut, bl, rx_done, frame_err, err_cnt
   );

   modport slave (
      input  rx_data, rx_valid,
      output per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off,
             pu, nut, bl, rx_done, frame_err, err_cnt
   );
endinterface

// File: rtl/pulse_param_loader.sv
// Parses SYNC_BYTE + 20 payload bytes (+ XOR checksum if PARAM_CKSUM_EN) and commits the set atomically.
// Latency: committed set and rx_done appear one clk_pll after the last frame byte is sampled.
// Backpressure: none; rx_valid sampled every cycle, a TIMEOUT_CYC inter-byte gap aborts the frame.
module pulse_param_loader
   import pulse_param_loader_pkg::*;
#(
   parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
   input logic                 clk_pll,
   input logic                 reset,
   pulse_param_loader_if.slave bus
);

   localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [4:0]    LAST_IDX   = 5'(PAYLOAD_LEN - 1);

   state_t        state;
   payload_t      shadow;
   payload_t      shadow_next;
   logic [4:0]    idx;
   logic [TW-1:0] timer;
   param_set_t    cur;
   logic          done_r;
   logic          ferr_r;
   logic [7:0]    err_cnt_r;
`ifdef PARAM_CKSUM_EN
   logic [7:0]    xsum;
`endif

   // Shadow is a byte shift register, so after 20 accepted bytes shadow[k] holds payload byte k
   always_comb begin
      for (int i = 0; i < PAYLOAD_LEN - 1; i++) begin
         shadow_next[i] = shadow[i + 1];
      end
      shadow_next[PAYLOAD_LEN - 1] = bus.rx_data;
   end

   always_ff @(posedge clk_pll or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         shadow    <= '{default: 8'h00};
         idx       <= '0;
         timer     <= '0;
         cur       <= PARAM_DEFAULTS;
         done_r    <= 1'b0;
         ferr_r    <= 1'b0;
         err_cnt_r <= 8'd0;
`ifdef PARAM_CKSUM_EN
         xsum      <= 8'd0;
`endif
      end else begin
         done_r <= 1'b0;
         ferr_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               timer <= '0;
               if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                  state <= ST_PAYLOAD;
                  idx   <= '0;
`ifdef PARAM_CKSUM_EN
                  xsum  <= 8'd0;
`endif
               end
            end
            ST_PAYLOAD: begin
               // An arriving byte wins over a timer expiring on the same edge
               if (bus.rx_valid) begin
                  timer  <= '0;
                  shadow <= shadow_next;
                  idx    <= idx + 5'd1;
`ifdef PARAM_CKSUM_EN
                  xsum   <= xsum ^ bus.rx_data;
                  if (idx == LAST_IDX) begin
                     state <= ST_CKSUM;
                  end
`else
                  if (idx == LAST_IDX) begin
                     state  <= ST_IDLE;
                     cur    <= unpack_payload(shadow_next);
                     done_r <= 1'b1;
                  end
`endif
               end else if (timer == TIMER_LAST) begin
                  state     <= ST_IDLE;
                  timer     <= '0;
                  ferr_r    <= 1'b1;
                  err_cnt_r <= sat_inc(err_cnt_r);
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`ifdef PARAM_CKSUM_EN
            ST_CKSUM: begin
               if (bus.rx_valid) begin
                  timer <= '0;
                  state <= ST_IDLE;
                  if (bus.rx_data == xsum) begin
                     cur    <= unpack_payload(shadow);
                     done_r <= 1'b1;
                  end else begin
                     ferr_r    <= 1'b1;
                     err_cnt_r <= sat_inc(err_cnt_r);
                  end
               end else if (timer == TIMER_LAST) begin
                  state     <= ST_IDLE;
                  timer     <= '0;
                  ferr_r    <= 1'b1;
                  err_cnt_r <= sat_inc(err_cnt_r);
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.per       = cur.per;
   assign bus.p1wid     = cur.p1wid;
   assign bus.del       = cur.del;
   assign bus.p2wid     = cur.p2wid;
   assign bus.nut_w     = cur.nut_w;
   assign bus.nut_d     = cur.nut_d;
   assign bus.cp        = cur.cp;
   assign bus.p_bl      = cur.p_bl;
   assign bus.p_bl_off  = cur.p_bl_off;
   assign bus.pu        = cur.pu;
   assign bus.nut       = cur.nut;
   assign bus.bl        = cur.bl;
   assign bus.rx_done   = done_r;
   assign bus.frame_err = ferr_r;
   assign bus.err_cnt   = err_cnt_r;

endmodule
